// File: rtl/shift_reg_univ.sv
// shift_reg_univ
//   Parametrised universal shift register: SHL / SHR / ROL / ROR / ASR,
//   single-step shifting under direct control, and a counted multi-step
//   shift with a busy/done handshake.
//
// Parameters
//   WIDTH  register width, >= 2
//   AMT_W  width of the step-count input, 2**AMT_W - 1 >= WIDTH
//
// Ports
//   clk    rising-edge clock
//   clr_n  asynchronous active-low reset
//   clr    synchronous clear (also aborts a counted shift)
//   ld     parallel load of din (idle only)
//   din    parallel load data
//   shift  one step in the live mode (idle only)
//   start  begin a counted shift of amt steps (idle only)
//   mode   shift mode, latched at start
//   amt    step count, latched at start
//   si     serial input, sampled live on every step
//   dout   register contents
//   so     bit shifted/rotated out by the most recent step
//   busy   counted shift in progress
//   done   one-cycle pulse when a counted shift completes
//
// States
//   S_IDLE | accepts clr / ld / start / shift in that priority
//   S_BUSY | one step per edge in latched mode until count reaches 0
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             si,
  output logic [WIDTH-1:0] dout,
  output logic             so,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             so_q, so_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;

  // Returns {so, dout} after one step. Reserved modes hold both values.
  function automatic logic [WIDTH:0] step_f(input logic [2:0]       m,
                                            input logic [WIDTH-1:0] d,
                                            input logic             s,
                                            input logic             so_cur);
    case (m)
      3'b000:  step_f = {d[WIDTH-1], d[WIDTH-2:0], s};
      3'b001:  step_f = {d[0], s, d[WIDTH-1:1]};
      3'b010:  step_f = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      3'b011:  step_f = {d[0], d[0], d[WIDTH-1:1]};
      3'b100:  step_f = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      default: step_f = {so_cur, d};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    so_d    = so_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (clr) begin
          dout_d = '0;
          so_d   = 1'b0;
        end else if (ld) begin
          dout_d = din;
        end else if (start) begin
          mode_d = mode;
          if (amt != '0) begin
            state_d = S_BUSY;
            cnt_d   = amt;
          end else begin
            // Zero-length shift completes immediately.
            done_d = 1'b1;
          end
        end else if (shift) begin
          {so_d, dout_d} = step_f(mode, dout_q, si, so_q);
        end
      end

      S_BUSY: begin
        if (clr) begin
          // Abort: no done pulse.
          state_d = S_IDLE;
          dout_d  = '0;
          so_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          {so_d, dout_d} = step_f(mode_q, dout_q, si, so_q);
          cnt_d = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      so_q    <= so_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign dout = dout_q;
  assign so   = so_q;
  assign busy = (state_q == S_BUSY);
  assign done = done_q;

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register. It generalises the fixed 8-bit left-shift register to WIDTH bits and five shift modes, and adds a multi-step counted shift with a busy/done handshake. It is used as a datapath operand shifter and serialiser beside the existing register blocks. It also supports single-step shifting under direct control.

Parameters:
WIDTH, 8, register width in bits; must be >= 2.
AMT_W, 4, width of the shift-amount input; 2**AMT_W - 1 >= WIDTH required.

Ports:
clk  input  1  clock; all state updates on rising edge.
clr_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous clear, active high.
ld  input  1  parallel load of din.
din  input  WIDTH  parallel load data.
shift  input  1  single-step shift in the current mode.
start  input  1  begin a counted shift of amt steps.
mode  input  3  shift mode; latched at start, used live for shift.
amt  input  AMT_W  step count; latched at start.
si  input  1  serial input bit.
dout  output  WIDTH  register contents (reg).
so  output  1  bit shifted or rotated out by the most recent step (reg).
busy  output  1  counted shift in progress (reg).
done  output  1  one-cycle pulse when a counted shift completes (reg).

Behaviour:
- Reset (clr_n=0, async): dout=0, so=0, busy=0, done=0, internal count=0, latched mode=0. Reset takes effect immediately, including mid-operation; no done pulse is produced.
- done defaults to 0 every cycle unless set as described below.
- Modes per step:
  - 000 SHL: dout <= {dout[W-2:0], si}; so <= dout[W-1].
  - 001 SHR: dout <= {si, dout[W-1:1]}; so <= dout[0].
  - 010 ROL: dout <= {dout[W-2:0], dout[W-1]}; so <= dout[W-1].
  - 011 ROR: dout <= {dout[0], dout[W-1:1]}; so <= dout[0].
  - 100 ASR: dout <= {dout[W-1], dout[W-1:1]}; so <= dout[0].
  - 101..111: reserved; the step leaves dout and so unchanged, but the step still counts.
- Idle priority (busy=0), highest first:
  1. clr: dout=0, so=0.
  2. ld: dout=din.
  3. start: latch mode and amt. If amt!=0, set busy=1 and count=amt. If amt=0, set done=1 next cycle; busy stays 0.
  4. shift: one step using the live mode.
  5. Otherwise hold.
- Busy state, priority:
  - clr: dout=0, so=0, busy=0, count=0; no done pulse (abort).
  - Otherwise, each edge performs one step in the latched mode and decrements count. On the edge where count==1, set busy=0 and done=1.
  - ld, start and shift are ignored while busy, and si is sampled live each step.
- Latency: start sampled at edge E with amt=N>0. Steps occur at edges E+1 .. E+N. The final dout is visible after E+N. busy is high from E to E+N. done is high for exactly the cycle following edge E+N.
- amt > WIDTH is legal and performs amt literal steps (rotates wrap, shifts fill fully).
- start at the same edge busy falls is ignored, because busy is still 1 at that edge. Back-to-back starts therefore need one idle cycle.
- No combinational path exists from any input to any output.

Test Plan:
1. Hold clr_n=0 during a counted shift, then release -> dout=0x00, so=0, busy=0, no done pulse; first edge after release with no control inputs holds 0x00.
2. ld din=0xA5; start mode=000 amt=3 si=1 -> busy high 3 cycles; dout steps 0x4B, 0x97, 0x2F; so steps 1, 0, 1; single done pulse as busy falls.
3. ld 0x81; start mode=011 amt=9 -> after 9 steps dout=0xC0, so=1, done pulse once.
4. ld 0x90; start mode=100 amt=2 -> dout 0xC8, then 0xE4; so=0; during busy, drive ld=1 din=0xFF and start=1 -> both ignored, result still 0xE4.
5. start amt=5; assert clr on the 2nd busy cycle -> dout=0x00, busy=0 next cycle, done never pulses; then start amt=0 -> done pulses next cycle, busy stays 0, dout unchanged.
6. Idle, ld 0x01, shift=1 mode=001 si=1 -> dout=0x80, so=1; ld and shift together -> load wins, dout=din.
